fft_stream_fifo: RTL and testbench

Parametrised single-clock Avalon-ST FIFO for the FFT streaming path. It buffers sample words together with their packet delimiters between the FFT control logic and the FFT core. It adds an optional store-and-forward packet mode, a fill level, a stored-packet count and an almost-full flag. It replaces fixed-width 15-bit packet FIFO instances where both sides share one clock.

---
 rtl/fft_fifo_pkg.sv | 30 +++
 rtl/fft_fifo_ram.sv | 34 +++
 rtl/fft_stream_fifo.sv | 128 ++++++++++++
 tb/tb_fft_stream_fifo.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fft_fifo_pkg
// Purpose  : Shared constants and helpers for the FFT streaming FIFO:
//            default widths, storage word layout and a clog2 helper.
// Revision : 1.0 - initial release
// ============================================================================
package fft_fifo_pkg;

  // Default payload width and word capacity.
  localparam int DEF_DATA_W = 15;
  localparam int DEF_DEPTH  = 64;

  // Storage word is {eop, sop, data}; packet flags sit just above the payload.
  localparam int SOP_OFS    = 0;
  localparam int EOP_OFS    = 1;
  localparam int WORD_XTRA  = 2;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fft_fifo_ram.sv
`default_nettype none
// ============================================================================
// Module   : fft_fifo_ram
// Purpose  : DEPTH x WIDTH simple dual-port storage, registered write and
//            asynchronous read, so it maps onto MLABs or plain registers.
// Revision : 1.0 - initial release
// ============================================================================
module fft_fifo_ram
  import fft_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_DATA_W + WORD_XTRA,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port: one word per clock when enabled.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port is combinational so the FIFO head is shown ahead.
  assign rdata = mem[raddr];

endmodule
`default_nettype wire

// File: rtl/fft_stream_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fft_stream_fifo
// Purpose  : Single-clock Avalon-ST packet FIFO with optional
//            store-and-forward gating, fill level, stored-packet count and
//            almost-full flag.
// Revision : 1.0 - initial release
// ============================================================================
module fft_stream_fifo
  import fft_fifo_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int STORE_FWD = 1,
  parameter int AFULL_TH  = DEPTH - 4
) (
  input  logic                     clk_clk,
  input  logic                     reset_reset_n,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_startofpacket,
  input  logic                     in_endofpacket,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_startofpacket,
  output logic                     out_endofpacket,
  output logic [clog2(DEPTH):0]    fill,
  output logic [clog2(DEPTH):0]    pkt_cnt,
  output logic                     almost_full
);

  localparam int AW      = clog2(DEPTH);
  localparam int CW      = AW + 1;
  localparam int WORD_W  = DATA_W + WORD_XTRA;
  localparam int SOP_POS = DATA_W + SOP_OFS;
  localparam int EOP_POS = DATA_W + EOP_OFS;
  localparam logic [CW-1:0] FULL_LVL  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_LVL = CW'(AFULL_TH);

  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     fill_nxt;
  logic [CW-1:0]     pkt_nxt;
  logic [WORD_W-1:0] wr_word;
  logic [WORD_W-1:0] rd_word;
  logic              wr_fire;
  logic              rd_fire;
  logic              wr_eop;
  logic              rd_eop;
  logic              in_pkt;   // head packet partially read

  assign wr_fire = in_valid && in_ready;
  assign rd_fire = out_valid && out_ready;
  assign wr_eop  = wr_fire && in_endofpacket;
  assign rd_eop  = rd_fire && rd_word[EOP_POS];
  assign wr_word = {in_endofpacket, in_startofpacket, in_data};

  fft_fifo_ram #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk_clk),
    .we    (wr_fire),
    .waddr (wr_ptr),
    .wdata (wr_word),
    .raddr (rd_ptr),
    .rdata (rd_word)
  );

  // Output gate: cut-through shows any stored word; store-and-forward waits
  // for a whole packet, unless full (oversize packet) or already mid-packet.
  generate
    if (STORE_FWD != 0) begin : g_store_fwd
      assign out_valid = (fill != '0) &&
                         ((pkt_cnt != '0) || (fill == FULL_LVL) || in_pkt);
    end else begin : g_cut_thru
      assign out_valid = (fill != '0);
    end
  endgenerate

  assign out_data          = rd_word[DATA_W-1:0];
  assign out_startofpacket = out_valid && rd_word[SOP_POS];
  assign out_endofpacket   = out_valid && rd_word[EOP_POS];

  // Next fill level and packet count from this cycle's transfers.
  always_comb begin
    fill_nxt = fill;
    pkt_nxt  = pkt_cnt;
    case ({wr_fire, rd_fire})
      2'b10:   fill_nxt = fill + CW'(1);
      2'b01:   fill_nxt = fill - CW'(1);
      default: fill_nxt = fill;
    endcase
    case ({wr_eop, rd_eop})
      2'b10:   pkt_nxt = pkt_cnt + CW'(1);
      2'b01:   pkt_nxt = pkt_cnt - CW'(1);
      default: pkt_nxt = pkt_cnt;
    endcase
  end

  // Pointers, counters, registered flags and the packet-in-progress state.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fill        <= '0;
      pkt_cnt     <= '0;
      in_ready    <= 1'b0;
      almost_full <= 1'b0;
      in_pkt      <= 1'b0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + AW'(1);
      if (rd_fire) begin
        rd_ptr <= rd_ptr + AW'(1);
        in_pkt <= !rd_word[EOP_POS];
      end
      fill        <= fill_nxt;
      pkt_cnt     <= pkt_nxt;
      in_ready    <= (fill_nxt != FULL_LVL);
      almost_full <= (fill_nxt >= AFULL_LVL);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fft_stream_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_stream_fifo
// Purpose  : Self-checking bench for fft_stream_fifo. Three instances share
//            the stimulus bus; a select routes handshakes to one of them:
//            0 = DEPTH 8 cut-through, 1 = DEPTH 8 store-and-forward,
//            2 = DEPTH 16 cut-through with AFULL_TH 12.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft_stream_fifo;

  logic        clk;
  logic        rst_n;
  logic [1:0]  sel;
  logic [14:0] in_data;
  logic        in_valid;
  logic        in_sop;
  logic        in_eop;
  logic        out_ready;

  int checks   = 0;
  int failures = 0;

  // Per-instance outputs.
  logic [14:0] ct_data, sf_data, d16_data;
  logic        ct_ov, sf_ov, d16_ov;
  logic        ct_ir, sf_ir, d16_ir;
  logic        ct_sop, sf_sop, d16_sop;
  logic        ct_eop, sf_eop, d16_eop;
  logic        ct_af, sf_af, d16_af;
  logic [3:0]  ct_fill, sf_fill, ct_pkt, sf_pkt;
  logic [4:0]  d16_fill, d16_pkt;

  // Observed outputs of the selected instance.
  logic [14:0] o_data;
  logic        o_ov, o_ir, o_sop, o_eop, o_af;
  logic [7:0]  o_fill, o_pkt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fft_stream_fifo #(.DATA_W(15), .DEPTH(8), .STORE_FWD(0)) u_ct (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .in_data(in_data), .in_valid(in_valid && (sel == 2'd0)), .in_ready(ct_ir),
    .in_startofpacket(in_sop), .in_endofpacket(in_eop),
    .out_data(ct_data), .out_valid(ct_ov), .out_ready(out_ready && (sel == 2'd0)),
    .out_startofpacket(ct_sop), .out_endofpacket(ct_eop),
    .fill(ct_fill), .pkt_cnt(ct_pkt), .almost_full(ct_af));

  fft_stream_fifo #(.DATA_W(15), .DEPTH(8), .STORE_FWD(1)) u_sf (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .in_data(in_data), .in_valid(in_valid && (sel == 2'd1)), .in_ready(sf_ir),
    .in_startofpacket(in_sop), .in_endofpacket(in_eop),
    .out_data(sf_data), .out_valid(sf_ov), .out_ready(out_ready && (sel == 2'd1)),
    .out_startofpacket(sf_sop), .out_endofpacket(sf_eop),
    .fill(sf_fill), .pkt_cnt(sf_pkt), .almost_full(sf_af));

  fft_stream_fifo #(.DATA_W(15), .DEPTH(16), .STORE_FWD(0), .AFULL_TH(12)) u_d16 (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .in_data(in_data), .in_valid(in_valid && (sel == 2'd2)), .in_ready(d16_ir),
    .in_startofpacket(in_sop), .in_endofpacket(in_eop),
    .out_data(d16_data), .out_valid(d16_ov), .out_ready(out_ready && (sel == 2'd2)),
    .out_startofpacket(d16_sop), .out_endofpacket(d16_eop),
    .fill(d16_fill), .pkt_cnt(d16_pkt), .almost_full(d16_af));

  // Route the selected instance onto the observation bus.
  always_comb begin
    o_data = d16_data; o_ov = d16_ov; o_ir = d16_ir; o_sop = d16_sop;
    o_eop = d16_eop; o_af = d16_af; o_fill = 8'(d16_fill); o_pkt = 8'(d16_pkt);
    case (sel)
      2'd0: begin
        o_data = ct_data; o_ov = ct_ov; o_ir = ct_ir; o_sop = ct_sop;
        o_eop = ct_eop; o_af = ct_af; o_fill = 8'(ct_fill); o_pkt = 8'(ct_pkt);
      end
      2'd1: begin
        o_data = sf_data; o_ov = sf_ov; o_ir = sf_ir; o_sop = sf_sop;
        o_eop = sf_eop; o_af = sf_af; o_fill = 8'(sf_fill); o_pkt = 8'(sf_pkt);
      end
      default: ;
    endcase
  end

  typedef struct {
    logic [1:0]  sel;
    logic        iv, isop, ieop, ordy;
    logic [14:0] idata;
    logic        ov, osop, oeop, ir, af;
    logic [14:0] odata;
    int          fill, pkt;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic [1:0] s, input logic iv, input logic isop,
                              input logic ieop, input int idata, input logic ordy,
                              input logic ov, input int odata, input logic osop,
                              input logic oeop, input logic ir, input int fl,
                              input int pk, input logic af);
    vec_t v;
    v.sel = s; v.iv = iv; v.isop = isop; v.ieop = ieop; v.idata = 15'(idata);
    v.ordy = ordy; v.ov = ov; v.odata = 15'(odata); v.osop = osop; v.oeop = oeop;
    v.ir = ir; v.fill = fl; v.pkt = pk; v.af = af;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input int d, input logic s, input logic e,
                       input logic r);
    in_valid = iv; in_data = 15'(d); in_sop = s; in_eop = e; out_ready = r;
  endtask

  // One table row: drive on the falling edge, compare pre-transfer state.
  task automatic apply_vec(input vec_t v, input int idx);
    @(negedge clk);
    sel = v.sel;
    drive(v.iv, int'(v.idata), v.isop, v.ieop, v.ordy);
    #1;
    chk($sformatf("row%0d out_valid", idx), 32'(o_ov), 32'(v.ov));
    chk($sformatf("row%0d in_ready", idx), 32'(o_ir), 32'(v.ir));
    chk($sformatf("row%0d fill", idx), 32'(o_fill), 32'(v.fill));
    chk($sformatf("row%0d pkt_cnt", idx), 32'(o_pkt), 32'(v.pkt));
    chk($sformatf("row%0d almost_full", idx), 32'(o_af), 32'(v.af));
    chk($sformatf("row%0d sop", idx), 32'(o_sop), 32'(v.osop));
    chk($sformatf("row%0d eop", idx), 32'(o_eop), 32'(v.oeop));
    if (v.ov) chk($sformatf("row%0d out_data", idx), 32'(o_data), 32'(v.odata));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wi, ri, mfill;
    bit started, w, r;

    rst_n = 1'b0; sel = 2'd0;
    drive(1'b0, 0, 1'b0, 1'b0, 1'b0);

    // Reset state of every instance.
    #12;
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s); #1;
      chk($sformatf("rst%0d in_ready", s), 32'(o_ir), 0);
      chk($sformatf("rst%0d out_valid", s), 32'(o_ov), 0);
      chk($sformatf("rst%0d fill", s), 32'(o_fill), 0);
      chk($sformatf("rst%0d pkt_cnt", s), 32'(o_pkt), 0);
      chk($sformatf("rst%0d almost_full", s), 32'(o_af), 0);
    end
    @(negedge clk); rst_n = 1'b1; #1;
    chk("release in_ready before edge", 32'(o_ir), 0);

    // Cut-through, DEPTH 8: fill completely, refuse a 9th word, then drain.
    for (int k = 0; k < 8; k++)
      add(2'd0, 1, k == 0, k == 7, k + 1, 0, k != 0, 1, k != 0, 0, 1, k, 0, k >= 4);
    add(2'd0, 1, 0, 0, 15'h0FF, 0, 1, 1, 1, 0, 0, 8, 1, 1);
    for (int j = 0; j < 8; j++)
      add(2'd0, 0, 0, 0, 0, 1, 1, j + 1, j == 0, j == 7, j != 0, 8 - j, 1, (8 - j) >= 4);
    add(2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);

    // Store-and-forward, DEPTH 8: 5-word packet held until EOP is stored.
    for (int k = 0; k < 5; k++)
      add(2'd1, 1, k == 0, k == 4, 15'h100 + k, 1, 0, 0, 0, 0, 1, k, 0, k >= 4);
    for (int j = 0; j < 5; j++)
      add(2'd1, 0, 0, 0, 0, 1, 1, 15'h100 + j, j == 0, j == 4, 1, 5 - j, 1, (5 - j) >= 4);
    add(2'd1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) apply_vec(tbl[i], i);

    // Oversize 12-word packet through DEPTH 8 store-and-forward.
    sel = 2'd1; wi = 0; ri = 0; mfill = 0; started = 0;
    for (int cyc = 0; cyc < 80 && ri < 12; cyc++) begin
      @(negedge clk);
      drive(wi < 12, 15'h200 + wi, wi == 0, wi == 11, 1'b1);
      #1;
      chk("big fill", 32'(o_fill), 32'(mfill));
      chk("big in_ready", 32'(o_ir), 32'(mfill != 8));
      chk("big out_valid", 32'(o_ov), started ? 32'(mfill != 0) : 32'(mfill == 8));
      w = in_valid && o_ir;
      r = o_ov;
      if (r) begin
        chk("big data", 32'(o_data), 32'(15'h200 + ri));
        chk("big sop", 32'(o_sop), 32'(ri == 0));
        chk("big eop", 32'(o_eop), 32'(ri == 11));
        ri++;
        started = 1;
      end
      if (w) wi++;
      mfill = mfill + int'(w) - int'(r);
    end
    chk("big words delivered", 32'(ri), 12);
    @(negedge clk); drive(1'b0, 0, 1'b0, 1'b0, 1'b0); #1;
    chk("big final fill", 32'(o_fill), 0);
    chk("big final pkt_cnt", 32'(o_pkt), 0);

    // Simultaneous traffic, DEPTH 16: hold fill at 4 across pointer wrap.
    sel = 2'd2;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); drive(1'b1, 15'h300 + k, 1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); drive(1'b1, 15'h304 + i, 1'b0, 1'b0, 1'b1); #1;
      chk($sformatf("sim%0d fill", i), 32'(o_fill), 4);
      chk($sformatf("sim%0d in_ready", i), 32'(o_ir), 1);
      chk($sformatf("sim%0d data", i), 32'(o_ov ? o_data : 15'h7FFF), 32'(15'h300 + i));
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); drive(1'b0, 0, 1'b0, 1'b0, 1'b1); #1;
      chk($sformatf("drain%0d data", i), 32'(o_ov ? o_data : 15'h7FFF), 32'(15'h314 + i));
    end
    @(negedge clk); drive(1'b0, 0, 1'b0, 1'b0, 1'b0); #1;
    chk("sim empty fill", 32'(o_fill), 0);
    chk("sim empty out_valid", 32'(o_ov), 0);

    // almost_full with AFULL_TH 12.
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk); drive(k < 12, 15'h400 + k, 1'b0, 1'b0, 1'b0); #1;
      chk($sformatf("af%0d fill", k), 32'(o_fill), 32'(k));
      chk($sformatf("af%0d almost_full", k), 32'(o_af), 32'(k >= 12));
    end
    @(negedge clk); drive(1'b0, 0, 1'b0, 1'b0, 1'b1);
    @(negedge clk); drive(1'b0, 0, 1'b0, 1'b0, 1'b0); #1;
    chk("af fall fill", 32'(o_fill), 11);
    chk("af fall almost_full", 32'(o_af), 0);

    // Mid-packet asynchronous reset on the cut-through instance.
    sel = 2'd0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); drive(1'b1, 15'h500 + k, k == 0, k == 1, 1'b0);
    end
    @(negedge clk); drive(1'b0, 0, 1'b0, 1'b0, 1'b0); #1;
    chk("pre-rst fill", 32'(o_fill), 3);
    chk("pre-rst pkt_cnt", 32'(o_pkt), 1);
    chk("pre-rst out_valid", 32'(o_ov), 1);
    rst_n = 1'b0; #1;
    chk("async rst fill", 32'(o_fill), 0);
    chk("async rst pkt_cnt", 32'(o_pkt), 0);
    chk("async rst out_valid", 32'(o_ov), 0);
    chk("async rst in_ready", 32'(o_ir), 0);
    chk("async rst sop", 32'(o_sop), 0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("post-rst in_ready before edge", 32'(o_ir), 0);
    @(posedge clk); #1;
    chk("post-rst in_ready after edge", 32'(o_ir), 1);
    chk("post-rst fill", 32'(o_fill), 0);
    @(negedge clk); drive(1'b1, 15'h5AA, 1'b1, 1'b1, 1'b0);
    @(negedge clk); drive(1'b0, 0, 1'b0, 1'b0, 1'b0); #1;
    chk("post-rst fill one", 32'(o_fill), 1);
    chk("post-rst head data", 32'(o_ov ? o_data : 15'h7FFF), 32'(15'h5AA));
    chk("post-rst pkt_cnt", 32'(o_pkt), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
